// File: rtl/vga_capture_if.sv
// Signal bundle between a VGA scan-out source and vga_capture: video in, framebuffer writes out.
// master = video source / write consumer, slave = the capture block.
interface vga_capture_if;
   logic        vsync;
   logic [3:0]  datar;
   logic [3:0]  datag;
   logic [3:0]  datab;
   logic [1:0]  blank;
   logic        wen;
   logic [11:0] wx;
   logic [11:0] wy;
   logic [11:0] wdata;
   logic        select;
   logic        frame_done;
   logic        overrun;

   modport master (
      output vsync, datar, datag, datab, blank,
      input  wen, wx, wy, wdata, select, frame_done, overrun
   );

   modport slave (
      input  vsync, datar, datag, datab, blank,
      output wen, wx, wy, wdata, select, frame_done, overrun
   );
endinterface

// File: rtl/vga_capture.sv
// Rebuilds pixel coordinates from a VGA signal bundle and emits framebuffer writes plus ping-pong select.
// Optional half-resolution capture when VGA_CAPTURE_DOWNSCALE_EN is defined.
module vga_capture #(
   parameter int MAX_W            = 640,
   parameter int MAX_H            = 480,
   parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
   input  logic         aclk,
   input  logic         areset,
   vga_capture_if.slave bus
);
   typedef enum logic [1:0] {
      SYNC_WAIT = 2'd0,
      VBLANK    = 2'd1,
      ACTIVE    = 2'd2
   } state_t;

   localparam logic [11:0] XLIM = 12'(MAX_W);
   localparam logic [11:0] YLIM = 12'(MAX_H);
   localparam logic [11:0] SAT  = '1;

   state_t      state_q, state_d;
   logic        vs_r, vs_p;
   logic [1:0]  blank_r, blank_p;
   logic [11:0] pix_r;
   logic [11:0] x, y;
   logic        vs_edge, hb_rise, vb_rise, pix_act;
   logic        in_bounds, dec_ok;
   logic        take, fd, wr, ovr_set;
   logic [11:0] wx_n, wy_n;
   logic        p_wen, p_fd, ovr;
   logic [11:0] p_wx, p_wy, p_wdata;

   // vsync is normalised to active-high at the input register
   always_ff @(posedge aclk) begin
      if (areset) begin
         vs_r    <= 1'b0;
         vs_p    <= 1'b0;
         blank_r <= '0;
         blank_p <= '0;
         pix_r   <= '0;
      end else begin
         vs_r    <= bus.vsync ^ VSYNC_ACTIVE_LOW;
         vs_p    <= vs_r;
         blank_r <= bus.blank;
         blank_p <= blank_r;
         pix_r   <= {bus.datab, bus.datag, bus.datar};
      end
   end

   assign vs_edge = vs_r & ~vs_p;
   assign hb_rise = blank_r[0] & ~blank_p[0];
   assign vb_rise = blank_r[1] & ~blank_p[1];
   assign pix_act = (blank_r == 2'b00);

   // vblank clear takes priority over the hblank line increment
   always_ff @(posedge aclk) begin
      if (areset) begin
         x <= '0;
         y <= '0;
      end else if (vs_edge || vb_rise) begin
         x <= '0;
         y <= '0;
      end else if (hb_rise) begin
         x <= '0;
         if (x != '0 && y != SAT) y <= y + 12'd1;
      end else if (pix_act && x != SAT) begin
         x <= x + 12'd1;
      end
   end

   assign in_bounds = (x < XLIM) && (y < YLIM);

`ifdef VGA_CAPTURE_DOWNSCALE_EN
   assign dec_ok = ~x[0] & ~y[0];
   assign wx_n   = {1'b0, x[11:1]};
   assign wy_n   = {1'b0, y[11:1]};
`else
   assign dec_ok = 1'b1;
   assign wx_n   = x;
   assign wy_n   = y;
`endif

   always_ff @(posedge aclk) begin
      if (areset) state_q <= SYNC_WAIT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      fd      = 1'b0;
      unique case (state_q)
         SYNC_WAIT: begin
            if (vs_edge) state_d = VBLANK;
         end
         VBLANK: begin
            if (pix_act && !vs_edge) begin
               state_d = ACTIVE;
               take    = 1'b1;
            end
         end
         ACTIVE: begin
            if (vs_edge) begin
               state_d = VBLANK;
            end else if (vb_rise) begin
               fd      = 1'b1;
               state_d = VBLANK;
            end else begin
               take = pix_act;
            end
         end
         default: state_d = SYNC_WAIT;
      endcase
   end

   assign wr      = take & in_bounds & dec_ok;
   assign ovr_set = take & ~in_bounds;

   // Two register stages after the input register give the fixed two-edge latency.
   always_ff @(posedge aclk) begin
      if (areset) begin
         p_wen   <= 1'b0;
         p_fd    <= 1'b0;
         ovr     <= 1'b0;
         p_wx    <= '0;
         p_wy    <= '0;
         p_wdata <= '0;
      end else begin
         p_wen <= wr;
         p_fd  <= fd;
         if (wr) begin
            p_wx    <= wx_n;
            p_wy    <= wy_n;
            p_wdata <= pix_r;
         end
         if (fd)           ovr <= 1'b0;
         else if (ovr_set) ovr <= 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         bus.wen        <= 1'b0;
         bus.wx         <= '0;
         bus.wy         <= '0;
         bus.wdata      <= '0;
         bus.select     <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         bus.wen        <= p_wen;
         bus.wx         <= p_wx;
         bus.wy         <= p_wy;
         bus.wdata      <= p_wdata;
         bus.frame_done <= p_fd;
         bus.overrun    <= ovr;
         if (p_fd) bus.select <= ~bus.select;
      end
   end
endmodule
